fnd_digit_scanner: RTL and testbench

FND_DIGIT_SCANNER -- requirements
Module: fnd_digit_scanner

---
 rtl/fnd_digit_scanner_if.sv | 24 ++
 rtl/fnd_digit_scanner.sv | 135 +++++++++++++
 tb/tb_fnd_digit_scanner.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fnd_digit_scanner_if.sv
// Bus bundle for fnd_digit_scanner: scan control and data in, digit/segment drive out.
interface fnd_digit_scanner_if #(
  parameter int DIGITS = 4
);
  localparam int SW = $clog2(DIGITS);

  logic                  i_en;
  logic [DIGITS*4-1:0]   i_data;
  logic [DIGITS-1:0]     i_blank_mask;
  logic [DIGITS-1:0]     o_digit;
  logic [7:0]            o_seg;
  logic [SW-1:0]         o_digitsel;
  logic                  o_frame_tick;

  modport master (
    output i_en, i_data, i_blank_mask,
    input  o_digit, o_seg, o_digitsel, o_frame_tick
  );

  modport slave (
    input  i_en, i_data, i_blank_mask,
    output o_digit, o_seg, o_digitsel, o_frame_tick
  );
endinterface

// File: rtl/fnd_digit_scanner.sv
// Multiplexed 7-segment (FND) scanner with per-slot guard blanking and frame-shadowed data.
// Optional leading-zero blanking is built when the macro FND_LZB_EN is defined.
module fnd_digit_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  fnd_digit_scanner_if.slave    bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DIGITS);
  localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_CNT  = PW'(GUARD);
  localparam logic [SW-1:0] LAST_PTR   = SW'(DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         ptr_q, ptr_d;
  logic [DIGITS*4-1:0]   shadow_q, shadow_d;
  logic                  load_q, load_d;
  logic                  tick_q, tick_d;
  logic [DIGITS-1:0]     digit_q, digit_d;
  logic [7:0]            seg_q, seg_d;
  logic                  slot_end_s;
  logic                  wrap_s;
  logic                  blank_s;
  logic [3:0]            nibble_s;
  logic [DIGITS-1:0]     lzb_s;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

`ifdef FND_LZB_EN
  logic zero_run_s;

  // Digit k>0 is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lzb_s      = '0;
    zero_run_s = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run_s = zero_run_s && (shadow_q[4*k +: 4] == 4'h0);
      lzb_s[k]   = zero_run_s;
    end
  end
`else
  assign lzb_s = '0;
`endif

  always_comb begin
    presc_d    = presc_q;
    ptr_d      = ptr_q;
    shadow_d   = shadow_q;
    load_d     = 1'b0;
    slot_end_s = bus.i_en && (presc_q == LAST_PRESC);
    wrap_s     = slot_end_s && (ptr_q == LAST_PTR);
    tick_d     = wrap_s;

    if (bus.i_en) begin
      presc_d = slot_end_s ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end

    if (slot_end_s) begin
      ptr_d = wrap_s ? '0 : ptr_q + SW'(1);
    end else begin
      ptr_d = ptr_q;
    end

    // load_q catches the first clock after reset so digit 0 never shows stale zeros.
    if (wrap_s || load_q) begin
      shadow_d = bus.i_data;
    end else begin
      shadow_d = shadow_q;
    end

    nibble_s = shadow_q[{ptr_q, 2'b00} +: 4];
    blank_s  = !bus.i_en || (presc_q < GUARD_CNT) || bus.i_blank_mask[ptr_q] || lzb_s[ptr_q];

    if (blank_s) begin
      digit_d = '1;
      seg_d   = 8'hFF;
    end else begin
      digit_d = ~(DIGITS'(1) << ptr_q);
      seg_d   = hex_to_seg(nibble_s);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      presc_q  <= '0;
      ptr_q    <= '0;
      shadow_q <= '0;
      load_q   <= 1'b1;
      tick_q   <= 1'b0;
      digit_q  <= '1;
      seg_q    <= 8'hFF;
    end else begin
      presc_q  <= presc_d;
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      load_q   <= load_d;
      tick_q   <= tick_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.o_digit      = digit_q;
  assign bus.o_seg        = seg_q;
  assign bus.o_digitsel   = ptr_q;
  assign bus.o_frame_tick = tick_q;
endmodule

// File: tb/tb_fnd_digit_scanner.sv
// Directed bench for fnd_digit_scanner (DIGITS=4, SCAN_DIV=8, GUARD=2).
module tb_fnd_digit_scanner;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fnd_digit_scanner_if #(.DIGITS(4)) bus ();

  fnd_digit_scanner #(
    .DIGITS   (4),
    .SCAN_DIV (8),
    .GUARD    (2)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("one_cold", 32'($countones(~bus.o_digit) <= 1), 32'd1);
  endtask

  task automatic check_all(input string tag, input logic [3:0] d, input logic [7:0] s,
                           input logic [1:0] sel, input logic t);
    check({tag, "_digit"}, 32'(bus.o_digit), 32'(d));
    check({tag, "_seg"},   32'(bus.o_seg), 32'(s));
    check({tag, "_sel"},   32'(bus.o_digitsel), 32'(sel));
    check({tag, "_tick"},  32'(bus.o_frame_tick), 32'(t));
  endtask

  // One 8-cycle slot: 2 guard cycles, then 6 cycles of dig/seg (dig=F, seg=FF for a blanked slot).
  task automatic run_slot(input string tag, input int s, input logic [3:0] dig, input logic [7:0] seg);
    for (int c = 0; c < 8; c++) begin
      step();
      check_all(tag,
                (c < 2) ? 4'hF : dig,
                (c < 2) ? 8'hFF : seg,
                (c == 7) ? 2'((s + 1) % 4) : 2'(s),
                (c == 7) && (s == 3));
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    bus.i_en         = 1'b0;
    bus.i_data       = 16'h0000;
    bus.i_blank_mask = 4'b0000;
    step();
    step();
    check_all("reset", 4'hF, 8'hFF, 2'd0, 1'b0);

    reset_n    = 1'b1;
    bus.i_en   = 1'b1;
    bus.i_data = 16'h1234;
    run_slot("f0s0", 0, 4'b1110, 8'h99);
    run_slot("f0s1", 1, 4'b1101, 8'hB0);
    run_slot("f0s2", 2, 4'b1011, 8'hA4);
    run_slot("f0s3", 3, 4'b0111, 8'hF9);

    run_slot("f1s0", 0, 4'b1110, 8'h99);
    run_slot("f1s1", 1, 4'b1101, 8'hB0);
    bus.i_data = 16'hABCD;
    run_slot("f1s2", 2, 4'b1011, 8'hA4);
    run_slot("f1s3", 3, 4'b0111, 8'hF9);

    run_slot("f2s0", 0, 4'b1110, 8'hA1);
    run_slot("f2s1", 1, 4'b1101, 8'hC6);
    run_slot("f2s2", 2, 4'b1011, 8'h83);
    run_slot("f2s3", 3, 4'b0111, 8'h88);

    bus.i_blank_mask = 4'b0100;
    run_slot("mask0", 0, 4'b1110, 8'hA1);
    run_slot("mask1", 1, 4'b1101, 8'hC6);
    run_slot("mask2", 2, 4'hF, 8'hFF);
    run_slot("mask3", 3, 4'b0111, 8'h88);
    bus.i_blank_mask = 4'b0000;

    run_slot("frz0", 0, 4'b1110, 8'hA1);
    for (int c = 0; c < 5; c++) begin
      step();
      check_all("frz1_pre", (c < 2) ? 4'hF : 4'b1101, (c < 2) ? 8'hFF : 8'hC6, 2'd1, 1'b0);
    end
    bus.i_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_all("frz_hold", 4'hF, 8'hFF, 2'd1, 1'b0);
    end
    bus.i_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_all("frz_resume", 4'b1101, 8'hC6, (c == 2) ? 2'd2 : 2'd1, 1'b0);
    end
    run_slot("frz2", 2, 4'b1011, 8'h83);
    run_slot("frz3", 3, 4'b0111, 8'h88);

    run_slot("rst0", 0, 4'b1110, 8'hA1);
    run_slot("rst1", 1, 4'b1101, 8'hC6);
    for (int c = 0; c < 3; c++) begin
      step();
      check_all("rst2_pre", (c < 2) ? 4'hF : 4'b1011, (c < 2) ? 8'hFF : 8'h83, 2'd2, 1'b0);
    end
    reset_n = 1'b0;
    step();
    check_all("mid_reset", 4'hF, 8'hFF, 2'd0, 1'b0);
    step();
    check_all("mid_reset_hold", 4'hF, 8'hFF, 2'd0, 1'b0);
    reset_n    = 1'b1;
    bus.i_data = 16'h5678;
    run_slot("post0", 0, 4'b1110, 8'h80);
    run_slot("post1", 1, 4'b1101, 8'hF8);
    run_slot("post2", 2, 4'b1011, 8'h82);
    bus.i_data = 16'h0070;
    run_slot("post3", 3, 4'b0111, 8'h92);

`ifdef FND_LZB_EN
    run_slot("lzb70_0", 0, 4'b1110, 8'hC0);
    run_slot("lzb70_1", 1, 4'b1101, 8'hF8);
    run_slot("lzb70_2", 2, 4'hF, 8'hFF);
    bus.i_data = 16'h0000;
    run_slot("lzb70_3", 3, 4'hF, 8'hFF);
    run_slot("lzb00_0", 0, 4'b1110, 8'hC0);
    run_slot("lzb00_1", 1, 4'hF, 8'hFF);
    run_slot("lzb00_2", 2, 4'hF, 8'hFF);
    run_slot("lzb00_3", 3, 4'hF, 8'hFF);
`else
    run_slot("nolzb70_0", 0, 4'b1110, 8'hC0);
    run_slot("nolzb70_1", 1, 4'b1101, 8'hF8);
    run_slot("nolzb70_2", 2, 4'b1011, 8'hC0);
    bus.i_data = 16'h0000;
    run_slot("nolzb70_3", 3, 4'b0111, 8'hC0);
    run_slot("nolzb00_0", 0, 4'b1110, 8'hC0);
    run_slot("nolzb00_1", 1, 4'b1101, 8'hC0);
    run_slot("nolzb00_2", 2, 4'b1011, 8'hC0);
    run_slot("nolzb00_3", 3, 4'b0111, 8'hC0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
